// File: rtl/instr_cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package instr_cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } cache_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    function automatic int off_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int idx_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Byte-offset bits (2) are not part of the tag, index or word offset.
    function automatic int tag_bits(input int addr_width, input int num_lines, input int words_per_line);
        return addr_width - 2 - off_bits(words_per_line) - idx_bits(num_lines);
    endfunction

endpackage

// File: rtl/instr_cache_fill_ctrl.sv
// Refill sequencer: latches the missing line address, runs the memory handshake
// and counts refill beats; a flush during a refill poisons the line being fetched.
//
//  state | meaning
//  IDLE  | lookups served from the arrays; a miss (without flush) starts a refill
//  REQ   | mem_req_o held with the latched line address until mem_ready_i
//  FILL  | one data-array write per mem_rvalid_i beat until the line is complete
module instr_cache_fill_ctrl
    import instr_cache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    localparam int OFFB          = off_bits(WORDS_PER_LINE)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  miss_i,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] line_addr_i,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  rep_en_o,
    output logic [OFFB-1:0]       beat_o,
    output logic                  start_o,
    output logic                  line_done_o,
    output logic                  set_valid_o
);

    cache_state_t          state;
    logic [OFFB-1:0]       beat_cnt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  poison;
    logic                  last_beat;

    assign last_beat   = (beat_cnt == OFFB'(WORDS_PER_LINE - 1));
    assign start_o     = (state == IDLE) && miss_i && !flush_i;
    assign rep_en_o    = (state == FILL) && mem_rvalid_i;
    assign line_done_o = rep_en_o && last_beat;
    // A flush landing on the final beat must also leave the line invalid.
    assign set_valid_o = line_done_o && !poison && !flush_i;
    assign mem_req_o   = (state == REQ);
    assign mem_addr_o  = lat_addr;
    assign beat_o      = beat_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            beat_cnt <= '0;
            lat_addr <= '0;
            poison   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_o) begin
                        state    <= REQ;
                        lat_addr <= line_addr_i;
                        poison   <= 1'b0;
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        poison <= 1'b1;
                    end
                    if (mem_ready_i) begin
                        state    <= FILL;
                        beat_cnt <= '0;
                    end
                end
                FILL: begin
                    if (flush_i) begin
                        poison <= 1'b1;
                    end
                    if (rep_en_o) begin
                        if (last_beat) begin
                            state    <= IDLE;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/instr_cache_dm.sv
// Direct-mapped instruction cache: tag/valid/data arrays with a zero-latency hit
// path; misses stall fetch while instr_cache_fill_ctrl refills one line.
module instr_cache_dm
    import instr_cache_pkg::*;
#(
    parameter int          NUM_LINES      = 16,
    parameter int          WORDS_PER_LINE = 4,
    parameter int          ADDR_WIDTH     = 32,
    parameter logic [31:0] NOP_INSTR      = NOP_INSTR_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  flush_i,
    output logic [31:0]           rd_o,
    output logic                  instr_miss_f_o,
    output logic                  instr_cache_rep_en_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i
);

    localparam int OFFB = off_bits(WORDS_PER_LINE);
    localparam int IDXB = idx_bits(NUM_LINES);
    localparam int TAGB = tag_bits(ADDR_WIDTH, NUM_LINES, WORDS_PER_LINE);
    localparam int TAG_LSB = OFFB + IDXB + 2;

    logic [OFFB-1:0]       offset;
    logic [IDXB-1:0]       index;
    logic [TAGB-1:0]       tag;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [IDXB-1:0]       fill_index;
    logic [TAGB-1:0]       fill_tag;

    logic [NUM_LINES-1:0]  valid_q;
    logic [TAGB-1:0]       tag_arr  [NUM_LINES];
    logic [31:0]           data_arr [NUM_LINES][WORDS_PER_LINE];

    logic                  hit;
    logic [OFFB-1:0]       beat;
    logic                  start;
    logic                  line_done;
    logic                  set_valid;
    logic                  unused_addr_bits;

    assign offset    = addr[OFFB+1:2];
    assign index     = addr[TAG_LSB-1:OFFB+2];
    assign tag       = addr[ADDR_WIDTH-1:TAG_LSB];
    assign line_addr = {addr[ADDR_WIDTH-1:OFFB+2], {(OFFB+2){1'b0}}};

    // The refill target is taken from the latched request address, not the live PC.
    assign fill_index = mem_addr_o[TAG_LSB-1:OFFB+2];
    assign fill_tag   = mem_addr_o[ADDR_WIDTH-1:TAG_LSB];

    assign unused_addr_bits = ^{addr[1:0], mem_addr_o[OFFB+1:0]};

    assign hit            = valid_q[index] && (tag_arr[index] == tag);
    assign instr_miss_f_o = !hit;
    assign rd_o           = hit ? data_arr[index][offset] : NOP_INSTR;

    instr_cache_fill_ctrl #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_fill_ctrl (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .miss_i       (instr_miss_f_o),
        .flush_i      (flush_i),
        .line_addr_i  (line_addr),
        .mem_ready_i  (mem_ready_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .rep_en_o     (instr_cache_rep_en_o),
        .beat_o       (beat),
        .start_o      (start),
        .line_done_o  (line_done),
        .set_valid_o  (set_valid)
    );

    // The victim line is invalidated as soon as its refill starts so no lookup
    // can hit on a half-overwritten line under its old tag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            if (start) begin
                valid_q[index] <= 1'b0;
            end
            if (set_valid) begin
                valid_q[fill_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (instr_cache_rep_en_o) begin
            data_arr[fill_index][beat] <= mem_rdata_i;
        end
        if (line_done) begin
            tag_arr[fill_index] <= fill_tag;
        end
    end

endmodule

// File: tb/tb_instr_cache_dm.sv
// Table-driven bench for instr_cache_dm with default parameters; expected outputs
// are queued when a vector is driven and compared at the following falling edge.
module tb_instr_cache_dm;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        flush;
    logic [31:0] rd;
    logic        miss;
    logic        rep_en;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic        flush;
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_miss;
        logic [31:0] e_rd;
        logic        e_req;
        logic [31:0] e_maddr;
        logic        e_rep;
    } vec_t;

    vec_t  vecs[$];
    vec_t  post_rst[$];
    vec_t  sb[$];
    string sb_lbl[$];

    always #5 clk = ~clk;

    instr_cache_dm dut (
        .clk_i                (clk),
        .rst_n_i              (rst_n),
        .addr                 (addr),
        .flush_i              (flush),
        .rd_o                 (rd),
        .instr_miss_f_o       (miss),
        .instr_cache_rep_en_o (rep_en),
        .mem_req_o            (mem_req),
        .mem_addr_o           (mem_addr),
        .mem_ready_i          (mem_ready),
        .mem_rvalid_i         (mem_rvalid),
        .mem_rdata_i          (mem_rdata)
    );

    function automatic vec_t mk(logic [31:0] a, logic f, logic rdy, logic rv, logic [31:0] d,
                                logic em, logic [31:0] erd, logic ereq, logic [31:0] ema, logic erep);
        vec_t v;
        v.addr = a; v.flush = f; v.ready = rdy; v.rvalid = rv; v.rdata = d;
        v.e_miss = em; v.e_rd = erd; v.e_req = ereq; v.e_maddr = ema; v.e_rep = erep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input string lbl);
        addr       = v.addr;
        flush      = v.flush;
        mem_ready  = v.ready;
        mem_rvalid = v.rvalid;
        mem_rdata  = v.rdata;
        sb.push_back(v);
        sb_lbl.push_back(lbl);
    endtask

    task automatic compare_out();
        vec_t  e;
        string l;
        e = sb.pop_front();
        l = sb_lbl.pop_front();
        chk({l, ".miss"},   32'(miss),    32'(e.e_miss));
        chk({l, ".rd"},     rd,           e.e_rd);
        chk({l, ".req"},    32'(mem_req), 32'(e.e_req));
        chk({l, ".maddr"},  mem_addr,     e.e_maddr);
        chk({l, ".rep_en"}, 32'(rep_en),  32'(e.e_rep));
    endtask

    task automatic apply(input vec_t v, input string lbl);
        drive(v, lbl);
        @(negedge clk);
        compare_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // cold miss on line 0
        vecs.push_back(mk(32'h000, 0, 0, 0, 0,            1, NOP,          0, 32'h000, 0));
        vecs.push_back(mk(32'h000, 0, 1, 0, 0,            1, NOP,          1, 32'h000, 0));
        vecs.push_back(mk(32'h000, 0, 0, 1, 32'hA0,       1, NOP,          0, 32'h000, 1));
        vecs.push_back(mk(32'h000, 0, 0, 1, 32'hA1,       1, NOP,          0, 32'h000, 1));
        vecs.push_back(mk(32'h000, 0, 0, 1, 32'hA2,       1, NOP,          0, 32'h000, 1));
        vecs.push_back(mk(32'h000, 0, 0, 1, 32'hA3,       1, NOP,          0, 32'h000, 1));
        vecs.push_back(mk(32'h000, 0, 0, 0, 0,            0, 32'hA0,       0, 32'h000, 0));
        // line reuse
        vecs.push_back(mk(32'h004, 0, 0, 0, 0,            0, 32'hA1,       0, 32'h000, 0));
        vecs.push_back(mk(32'h008, 0, 0, 0, 0,            0, 32'hA2,       0, 32'h000, 0));
        vecs.push_back(mk(32'h00C, 0, 0, 0, 0,            0, 32'hA3,       0, 32'h000, 0));
        // conflict eviction of index 0 by tag 1
        vecs.push_back(mk(32'h100, 0, 0, 0, 0,            1, NOP,          0, 32'h000, 0));
        vecs.push_back(mk(32'h100, 0, 1, 0, 0,            1, NOP,          1, 32'h100, 0));
        vecs.push_back(mk(32'h100, 0, 0, 1, 32'hB0,       1, NOP,          0, 32'h100, 1));
        vecs.push_back(mk(32'h100, 0, 0, 1, 32'hB1,       1, NOP,          0, 32'h100, 1));
        vecs.push_back(mk(32'h100, 0, 0, 1, 32'hB2,       1, NOP,          0, 32'h100, 1));
        vecs.push_back(mk(32'h100, 0, 0, 1, 32'hB3,       1, NOP,          0, 32'h100, 1));
        vecs.push_back(mk(32'h100, 0, 0, 0, 0,            0, 32'hB0,       0, 32'h100, 0));
        vecs.push_back(mk(32'h000, 0, 0, 0, 0,            1, NOP,          0, 32'h100, 0));
        // stalled request, PC wanders, rvalid ignored in REQ, gappy beats
        vecs.push_back(mk(32'h000, 0, 0, 0, 0,            1, NOP,          1, 32'h000, 0));
        vecs.push_back(mk(32'h100, 0, 0, 1, 32'hDEAD,     1, NOP,          1, 32'h000, 0));
        vecs.push_back(mk(32'h000, 0, 0, 0, 0,            1, NOP,          1, 32'h000, 0));
        vecs.push_back(mk(32'h000, 0, 1, 0, 0,            1, NOP,          1, 32'h000, 0));
        vecs.push_back(mk(32'h000, 0, 0, 1, 32'h90,       1, NOP,          0, 32'h000, 1));
        vecs.push_back(mk(32'h000, 0, 1, 0, 0,            1, NOP,          0, 32'h000, 0));
        vecs.push_back(mk(32'h000, 0, 0, 1, 32'h91,       1, NOP,          0, 32'h000, 1));
        vecs.push_back(mk(32'h000, 0, 0, 0, 0,            1, NOP,          0, 32'h000, 0));
        vecs.push_back(mk(32'h000, 0, 0, 1, 32'h92,       1, NOP,          0, 32'h000, 1));
        vecs.push_back(mk(32'h000, 0, 0, 0, 0,            1, NOP,          0, 32'h000, 0));
        vecs.push_back(mk(32'h000, 0, 0, 1, 32'h93,       1, NOP,          0, 32'h000, 1));
        vecs.push_back(mk(32'h000, 0, 1, 1, 32'hDEAD,     0, 32'h90,       0, 32'h000, 0));
        vecs.push_back(mk(32'h004, 0, 0, 1, 32'hBEEF,     0, 32'h91,       0, 32'h000, 0));
        vecs.push_back(mk(32'h00C, 0, 0, 0, 0,            0, 32'h93,       0, 32'h000, 0));
        // flush mid-FILL of line 0x40: fill completes but nothing stays valid
        vecs.push_back(mk(32'h040, 0, 0, 0, 0,            1, NOP,          0, 32'h000, 0));
        vecs.push_back(mk(32'h040, 0, 1, 0, 0,            1, NOP,          1, 32'h040, 0));
        vecs.push_back(mk(32'h040, 0, 0, 1, 32'hC0,       1, NOP,          0, 32'h040, 1));
        vecs.push_back(mk(32'h040, 1, 0, 1, 32'hC1,       1, NOP,          0, 32'h040, 1));
        vecs.push_back(mk(32'h040, 0, 0, 1, 32'hC2,       1, NOP,          0, 32'h040, 1));
        vecs.push_back(mk(32'h040, 0, 0, 1, 32'hC3,       1, NOP,          0, 32'h040, 1));
        vecs.push_back(mk(32'h000, 0, 0, 0, 0,            1, NOP,          0, 32'h040, 0));
        vecs.push_back(mk(32'h040, 0, 0, 0, 0,            1, NOP,          1, 32'h000, 0));
        vecs.push_back(mk(32'h000, 0, 1, 0, 0,            1, NOP,          1, 32'h000, 0));
        vecs.push_back(mk(32'h000, 0, 0, 1, 32'hD0,       1, NOP,          0, 32'h000, 1));
        vecs.push_back(mk(32'h000, 0, 0, 1, 32'hD1,       1, NOP,          0, 32'h000, 1));
        vecs.push_back(mk(32'h000, 0, 0, 1, 32'hD2,       1, NOP,          0, 32'h000, 1));
        vecs.push_back(mk(32'h000, 0, 0, 1, 32'hD3,       1, NOP,          0, 32'h000, 1));
        vecs.push_back(mk(32'h000, 0, 0, 0, 0,            0, 32'hD0,       0, 32'h000, 0));
        vecs.push_back(mk(32'h004, 0, 0, 0, 0,            0, 32'hD1,       0, 32'h000, 0));
        // flush in IDLE together with a miss: no refill, everything invalid after
        vecs.push_back(mk(32'h040, 1, 0, 0, 0,            1, NOP,          0, 32'h000, 0));
        vecs.push_back(mk(32'h000, 0, 0, 0, 0,            1, NOP,          0, 32'h000, 0));
        vecs.push_back(mk(32'h000, 0, 1, 0, 0,            1, NOP,          1, 32'h000, 0));
        vecs.push_back(mk(32'h000, 0, 0, 1, 32'hE0,       1, NOP,          0, 32'h000, 1));
        vecs.push_back(mk(32'h000, 0, 0, 1, 32'hE1,       1, NOP,          0, 32'h000, 1));

        // after a reset that aborted the E-line fill: line 0 cold, refill with flush on last beat
        post_rst.push_back(mk(32'h000, 0, 0, 0, 0,        1, NOP,          0, 32'h000, 0));
        post_rst.push_back(mk(32'h000, 0, 1, 0, 0,        1, NOP,          1, 32'h000, 0));
        post_rst.push_back(mk(32'h000, 0, 0, 1, 32'hF0,   1, NOP,          0, 32'h000, 1));
        post_rst.push_back(mk(32'h000, 0, 0, 1, 32'hF1,   1, NOP,          0, 32'h000, 1));
        post_rst.push_back(mk(32'h000, 0, 0, 1, 32'hF2,   1, NOP,          0, 32'h000, 1));
        post_rst.push_back(mk(32'h000, 1, 0, 1, 32'hF3,   1, NOP,          0, 32'h000, 1));
        post_rst.push_back(mk(32'h000, 0, 0, 0, 0,        1, NOP,          0, 32'h000, 0));

        // power-on reset; flush held high so the first edge after release starts nothing
        rst_n = 1'b0;
        drive(mk(32'h000, 1, 0, 0, 0, 1, NOP, 0, 32'h000, 0), "reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_out();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

        // asynchronous reset two beats into FILL
        drive(mk(32'h000, 1, 0, 0, 0, 1, NOP, 0, 32'h000, 0), "rst_mid_fill");
        rst_n = 1'b0;
        #1;
        compare_out();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (post_rst[i]) apply(post_rst[i], $sformatf("r%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
